dmem_wait: RTL and testbench

//  Parametrised data memory for the mcpu data port. Single-port word RAM with byte enables.

---
 rtl/cpu_mem_pkg.sv | 9 +
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_wait.sv | 130 +++++++++++++
 tb/tb_dmem_wait.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the mcpu data-memory slice.
package cpu_mem_pkg;

   typedef enum logic [1:0] {MS_IDLE, MS_WAIT, MS_RESP} mem_state_t;

   localparam int unsigned BYTES_PER_WORD   = 4;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: registered read, per-byte write, no reset on contents.
module dmem_array
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  CLK,
   input  logic                  EN,
   input  logic                  WE,
   input  logic [3:0]            BE,
   input  logic [DEPTH_LOG2-1:0] A,
   input  logic [31:0]           WD,
   output logic [31:0]           RD
);

   localparam int unsigned WORDS = 1 << DEPTH_LOG2;

   logic [31:0] mem [WORDS];

   always_ff @(posedge CLK) begin
      if (EN) begin
         if (WE) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
               if (BE[i]) begin
                  mem[A][8*i +: 8] <= WD[8*i +: 8];
               end
            end
         end else begin
            RD <= mem[A];
         end
      end
   end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with REQ/READY handshake, programmable wait states and range error response.
module dmem_wait
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned WAIT_CYC   = 0,
   parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              REQ,
   input  logic              WE,
   input  logic [3:0]        BE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [31:0]       WD,
   output logic              READY,
   output logic [31:0]       RD,
   output logic              RD_VALID,
   output logic              DONE,
   output logic              ERR
);

   localparam logic [3:0] WAIT_LAST = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

   mem_state_t            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, oor_q;
   logic [3:0]            be_q;
   logic [DEPTH_LOG2-1:0] a_q;
   logic [31:0]           wd_q;

   logic                  accept, go_resp, in_idle, oor_live;
   logic                  arr_we, arr_oor;
   logic [3:0]            arr_be;
   logic [DEPTH_LOG2-1:0] arr_a;
   logic [31:0]           arr_wd, arr_rd;

   assign in_idle  = (state_q == MS_IDLE);
   assign oor_live = (ADDR >> DEPTH_LOG2) != '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      go_resp = 1'b0;
      unique case (state_q)
         MS_IDLE: begin
            if (REQ) begin
               accept = 1'b1;
               cnt_d  = 4'd0;
               if (WAIT_CYC == 0) begin
                  state_d = MS_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = MS_WAIT;
               end
            end
         end
         MS_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = MS_RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         MS_RESP: state_d = MS_IDLE;
         default: state_d = MS_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= MS_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         oor_q   <= 1'b0;
         be_q    <= 4'd0;
         a_q     <= '0;
         wd_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q  <= WE;
            oor_q <= oor_live;
            be_q  <= BE;
            a_q   <= ADDR[DEPTH_LOG2-1:0];
            wd_q  <= WD;
         end
      end
   end

   // With no wait states the RAM is hit on the accept edge, so use the live request there.
   always_comb begin
      if (in_idle) begin
         arr_we  = WE;
         arr_oor = oor_live;
         arr_be  = BE;
         arr_a   = ADDR[DEPTH_LOG2-1:0];
         arr_wd  = WD;
      end else begin
         arr_we  = we_q;
         arr_oor = oor_q;
         arr_be  = be_q;
         arr_a   = a_q;
         arr_wd  = wd_q;
      end
   end

   dmem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .CLK (CLK),
      .EN  (go_resp && RESET_N),
      .WE  (arr_we && !arr_oor),
      .BE  (arr_be),
      .A   (arr_a),
      .WD  (arr_wd),
      .RD  (arr_rd)
   );

   assign READY    = in_idle;
   assign DONE     = (state_q == MS_RESP);
   assign RD_VALID = DONE && !we_q;
   assign ERR      = DONE && oor_q;
   assign RD       = RD_VALID ? (oor_q ? ERR_DATA : arr_rd) : 32'd0;

endmodule

// File: tb/tb_dmem_wait.sv
// Directed scoreboard bench for dmem_wait; dut 0 built with WAIT_CYC=0, dut 1 with WAIT_CYC=3.
module tb_dmem_wait;

   typedef struct packed {
      logic        is_wr;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic             CLK;
   logic             RESET_N;
   logic [1:0]       req, we, ready, rd_valid, done, err;
   logic [1:0][3:0]  be;
   logic [1:0][29:0] addr;
   logic [1:0][31:0] wd, rd;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   dmem_wait #(.ADDR_W(30), .DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut0 (
      .CLK(CLK), .RESET_N(RESET_N), .REQ(req[0]), .WE(we[0]), .BE(be[0]), .ADDR(addr[0]),
      .WD(wd[0]), .READY(ready[0]), .RD(rd[0]), .RD_VALID(rd_valid[0]), .DONE(done[0]),
      .ERR(err[0])
   );

   dmem_wait #(.ADDR_W(30), .DEPTH_LOG2(10), .WAIT_CYC(3)) u_dut1 (
      .CLK(CLK), .RESET_N(RESET_N), .REQ(req[1]), .WE(we[1]), .BE(be[1]), .ADDR(addr[1]),
      .WD(wd[1]), .READY(ready[1]), .RD(rd[1]), .RD_VALID(rd_valid[1]), .DONE(done[1]),
      .ERR(err[1])
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] b);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Issue one access on dut k and check its response against the scoreboard.
   task automatic access(input int k, input logic w, input logic [3:0] b, input logic [29:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      int   lat;
      bit   got;
      sb.push_back('{is_wr: w, rd: exp_rd, err: exp_err});
      @(negedge CLK);
      for (int i = 0; i < 50 && !ready[k]; i++) @(negedge CLK);
      if (!ready[k]) begin
         chk($sformatf("ready_timeout[%0d]", k), {31'd0, ready[k]}, 32'd1);
         void'(sb.pop_front());
         return;
      end
      req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wd[k] = d;
      @(posedge CLK);
      #1 req[k] = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge CLK);
         if (done[k]) begin
            got = 1'b1;
            lat = i;
         end
      end
      e = sb.pop_front();
      chk($sformatf("done_seen[%0d] a=%0h", k, a), {31'd0, got}, 32'd1);
      chk($sformatf("latency[%0d] a=%0h", k, a), 32'(lat), 32'(wait_of(k) + 1));
      chk($sformatf("rd_valid[%0d] a=%0h", k, a), {31'd0, rd_valid[k]}, {31'd0, !e.is_wr});
      chk($sformatf("err[%0d] a=%0h", k, a), {31'd0, err[k]}, {31'd0, e.err});
      if (!e.is_wr) chk($sformatf("rd[%0d] a=%0h", k, a), rd[k], e.rd);
      @(negedge CLK);
      chk($sformatf("pulse_end[%0d] a=%0h", k, a), {28'd0, done[k], rd_valid[k], err[k],
          ready[k]}, 32'd1);
      chk($sformatf("rd_zero[%0d] a=%0h", k, a), rd[k], 32'd0);
   endtask

   initial begin
      logic [31:0] model [16];
      logic [31:0] dat;
      logic [3:0]  bb;
      int          n_acc, n_resp, last, cyc;
      exp_t        e;
      logic [29:0] a2 [4];

      RESET_N = 1'b0;
      req = '0; we = '0; be = '0; addr = '0; wd = '0;
      repeat (2) @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_ready[%0d]", k), {31'd0, ready[k]}, 32'd1);
         chk($sformatf("reset_flags[%0d]", k), {29'd0, rd_valid[k], done[k], err[k]}, 32'd0);
         chk($sformatf("reset_rd[%0d]", k), rd[k], 32'd0);
      end
      RESET_N = 1'b1;

      for (int k = 0; k < 2; k++) begin
         // Byte-enable merge
         access(k, 1'b1, 4'hF, 30'd5, 32'h1122_3344, 32'd0, 1'b0);
         access(k, 1'b1, 4'b0101, 30'd5, 32'hAABB_CCDD, 32'd0, 1'b0);
         access(k, 1'b0, 4'hF, 30'd5, 32'd0, 32'h11BB_33DD, 1'b0);
         // Out-of-range
         access(k, 1'b1, 4'hF, 30'd0, 32'h00C0_FFEE, 32'd0, 1'b0);
         access(k, 1'b0, 4'hF, 30'd1 << 10, 32'd0, 32'hDEAD_BEEF, 1'b1);
         access(k, 1'b1, 4'hF, 30'd1 << 10, 32'h1234_5678, 32'd0, 1'b1);
         access(k, 1'b0, 4'hF, 30'd0, 32'd0, 32'h00C0_FFEE, 1'b0);
         // BE=0 read returns full word, BE=0 write leaves it alone
         access(k, 1'b1, 4'hF, 30'd9, 32'h9988_7766, 32'd0, 1'b0);
         access(k, 1'b0, 4'h0, 30'd9, 32'd0, 32'h9988_7766, 1'b0);
         access(k, 1'b1, 4'h0, 30'd9, 32'h0000_0000, 32'd0, 1'b0);
         access(k, 1'b0, 4'hF, 30'd9, 32'd0, 32'h9988_7766, 1'b0);
         // Store/load sweep over 16 words against a reference model
         for (int i = 0; i < 16; i++) begin
            dat = $urandom;
            model[i] = dat;
            access(k, 1'b1, 4'hF, 30'(32 + i), dat, 32'd0, 1'b0);
         end
         for (int i = 0; i < 16; i++) begin
            dat = $urandom;
            bb = 4'($urandom_range(0, 15));
            model[i] = merge(model[i], dat, bb);
            access(k, 1'b1, bb, 30'(32 + i), dat, 32'd0, 1'b0);
         end
         for (int i = 0; i < 16; i++) access(k, 1'b0, 4'hF, 30'(32 + i), 32'd0, model[i], 1'b0);
      end

      // REQ held across 4 reads on the wait-state build; junk fields while stalled
      for (int i = 0; i < 4; i++) begin
         a2[i] = 30'(10 + i);
         access(1, 1'b1, 4'hF, a2[i], 32'hA000_0000 + 32'(i), 32'd0, 1'b0);
      end
      access(1, 1'b1, 4'hF, 30'd20, 32'h2020_2020, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++)
         sb.push_back('{is_wr: 1'b0, rd: 32'hA000_0000 + 32'(i), err: 1'b0});
      n_acc = 0; n_resp = 0; last = -1; cyc = 0;
      for (int c = 0; c < 60 && n_resp < 4; c++) begin
         @(negedge CLK);
         cyc++;
         if (rd_valid[1]) begin
            e = sb.pop_front();
            chk($sformatf("held_rd%0d", n_resp), rd[1], e.rd);
            if (last >= 0) chk($sformatf("held_spacing%0d", n_resp), 32'(cyc - last), 32'd5);
            last = cyc;
            n_resp++;
         end
         if (ready[1] && n_acc < 4) begin
            req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = a2[n_acc]; wd[1] = 32'd0;
            n_acc++;
         end else if (ready[1]) begin
            req[1] = 1'b0;
         end else begin
            we[1] = 1'b1; be[1] = 4'hF; addr[1] = 30'd20; wd[1] = 32'hFFFF_FFFF;
         end
      end
      req[1] = 1'b0;
      chk("held_count", 32'(n_resp), 32'd4);
      access(1, 1'b0, 4'hF, 30'd20, 32'd0, 32'h2020_2020, 1'b0);

      // Reset in the 2nd wait cycle drops the pending write
      access(1, 1'b1, 4'hF, 30'd7, 32'h0707_0707, 32'd0, 1'b0);
      @(negedge CLK);
      req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 30'd7; wd[1] = 32'hCAFE_F00D;
      @(posedge CLK);
      #1 req[1] = 1'b0;
      @(posedge CLK);
      #2 RESET_N = 1'b0;
      #1 chk("rst_ready", {31'd0, ready[1]}, 32'd1);
      chk("rst_done", {31'd0, done[1]}, 32'd0);
      @(negedge CLK);
      chk("rst_done_hold", {30'd0, done[1], rd_valid[1]}, 32'd0);
      RESET_N = 1'b1;
      access(1, 1'b0, 4'hF, 30'd7, 32'd0, 32'h0707_0707, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
